// File: rtl/b_loader_pkg.sv
// b_loader_pkg: shared FSM state type and stream-length constant for b_loader
package b_loader_pkg;
  typedef enum logic [1:0] {FILL, FULL, STREAM} state_t;
  function automatic int stream_len(input int dim);
    return 4 * dim;
  endfunction
  localparam int DIM_DEFAULT = 8;
  localparam int STREAM_LEN = stream_len(DIM_DEFAULT);
endpackage

// File: rtl/b_loader.sv
// b_loader: buffers a DIM x DIM tile of B rows and streams it to the downstream skew buffer
// Ports: clk, rst (async, active high); wr_valid/wr_ready/wr_row row-write handshake;
//   start request to stream, busy/done/err status; en_out/Bout drive skew buffer en/Bin.
module b_loader
  import b_loader_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DIM = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic signed [BITS_AB-1:0] wr_row [DIM],
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      en_out,
  output logic signed [BITS_AB-1:0] Bout [DIM]
);
  localparam int SLEN = stream_len(DIM);
  localparam int WW = $clog2(DIM);
  localparam int SW = $clog2(SLEN);
  state_t r_state, w_state_nxt;
  logic [WW-1:0] r_wr_cnt, w_wr_cnt_nxt;
  logic [SW-1:0] r_st_cnt, w_st_cnt_nxt;
  logic signed [BITS_AB-1:0] r_buf [DIM][DIM];
  logic signed [BITS_AB-1:0] r_bout [DIM];
  logic r_en, r_done, r_err;
  logic w_accept, w_en_nxt, w_err_nxt, w_row_sel;
  always_comb begin
    w_state_nxt = r_state;
    w_wr_cnt_nxt = r_wr_cnt;
    w_st_cnt_nxt = r_st_cnt;
    w_accept = r_state == FILL && wr_valid;
    w_en_nxt = r_state == STREAM;
    w_err_nxt = start && r_state != FULL;
    w_row_sel = w_en_nxt && r_st_cnt < SW'(DIM);
    case (r_state)
      FILL: if (wr_valid) begin
        w_wr_cnt_nxt = r_wr_cnt + 1'b1;
        if (r_wr_cnt == WW'(DIM - 1)) begin
          w_state_nxt = FULL;
          w_wr_cnt_nxt = '0;
        end
      end
      FULL: if (start) begin
        w_state_nxt = STREAM;
        w_st_cnt_nxt = '0;
      end
      STREAM: begin
        w_st_cnt_nxt = r_st_cnt + 1'b1;
        if (r_st_cnt == SW'(SLEN - 1)) begin
          w_state_nxt = FILL;
          w_wr_cnt_nxt = '0;
          w_st_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= FILL;
      r_wr_cnt <= '0;
      r_st_cnt <= '0;
      r_en <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      for (int j = 0; j < DIM; j++) r_bout[j] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wr_cnt <= w_wr_cnt_nxt;
      r_st_cnt <= w_st_cnt_nxt;
      r_en <= w_en_nxt;
      // done marks the first idle output cycle after the last streamed beat
      r_done <= r_en & ~w_en_nxt;
      r_err <= w_err_nxt;
      for (int j = 0; j < DIM; j++) r_bout[j] <= w_row_sel ? r_buf[r_st_cnt[WW-1:0]][j] : '0;
    end
  // the tile store carries no reset: it is only read after a full fresh fill
  always_ff @(posedge clk)
    if (w_accept) r_buf[r_wr_cnt] <= wr_row;
  assign wr_ready = r_state == FILL;
  assign busy = r_en;
  assign en_out = r_en;
  assign done = r_done;
  assign err = r_err;
  assign Bout = r_bout;
endmodule

// File: tb/tb_b_loader.sv
// tb_b_loader: randomized self-checking bench for b_loader against a tile/stream model
module tb_b_loader;
  localparam int B = 8;
  localparam int D = 8;
  localparam int L = 4 * D;
  localparam int W = B * D;
  localparam int C = L + 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_valid = 1'b0;
  logic start = 1'b0;
  logic wr_ready, busy, done, err, en_out;
  logic signed [B-1:0] wr_row [D];
  logic signed [B-1:0] Bout [D];
  logic [W-1:0] bout_flat;
  logic [W-1:0] tile [D];
  logic cap_ok;
  logic cap_en [C];
  logic cap_busy [C];
  logic cap_done [C];
  logic cap_err [C];
  logic [W-1:0] cap_row [C];
  int total = 0;
  int bad = 0;

  b_loader #(.BITS_AB(B), .DIM(D)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row),
    .start(start), .busy(busy), .done(done), .err(err), .en_out(en_out), .Bout(Bout)
  );

  always #5 clk = ~clk;
  always_comb for (int j = 0; j < D; j++) bout_flat[j*B +: B] = Bout[j];

  function automatic logic [W-1:0] exp_row(input int k);
    return (k < D) ? tile[k % D] : '0;
  endfunction

  function automatic logic [W-1:0] rand_row();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [W-1:0] ramp_row(input int r);
    logic [W-1:0] v;
    for (int j = 0; j < D; j++) v[j*B +: B] = B'(D * r + j);
    return v;
  endfunction

  task automatic set_row(input logic [W-1:0] r);
    for (int j = 0; j < D; j++) wr_row[j] = r[j*B +: B];
  endtask

  task automatic write_row(input logic [W-1:0] r);
    set_row(r);
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic load_tile();
    for (int r = 0; r < D; r++) write_row(tile[r]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_stream();
    int t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!en_out && t < 5) begin
      @(negedge clk);
      t++;
    end
    cap_ok = en_out;
    for (int k = 0; k < C; k++) begin
      cap_en[k] = en_out;
      cap_busy[k] = busy;
      cap_done[k] = done;
      cap_err[k] = err;
      cap_row[k] = bout_flat;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({en_out, busy, done, err} !== 4'b0 || bout_flat !== '0) begin
      bad++;
      $display("FAIL reset_outputs en=%b busy=%b done=%b err=%b bout=%h want all zero", en_out, busy, done, err, bout_flat);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (wr_ready !== 1'b1 || en_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_release wr_ready=%b en=%b want 1 0", wr_ready, en_out);
    end
  endtask

  task automatic test_fill();
    for (int r = 0; r < D; r++) tile[r] = ramp_row(r);
    load_tile();
    total++;
    if (wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL fill_full wr_ready=%b want 0", wr_ready);
    end
    run_stream();
    for (int k = 0; k < C; k++) begin
      total++;
      if (!cap_ok || cap_en[k] !== (k < L) || cap_busy[k] !== (k < L) || cap_done[k] !== (k == L) || cap_err[k] !== 1'b0 || cap_row[k] !== exp_row(k)) begin
        bad++;
        $display("FAIL fill_stream cyc=%0d ok=%b en=%b busy=%b done=%b err=%b row=%h want en=%b done=%b row=%h",
                 k, cap_ok, cap_en[k], cap_busy[k], cap_done[k], cap_err[k], cap_row[k], k < L, k == L, exp_row(k));
      end
    end
  endtask

  task automatic test_early_start();
    do_reset();
    for (int r = 0; r < D; r++) tile[r] = rand_row();
    for (int r = 0; r < 5; r++) write_row(tile[r]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL early_err err=%b want 1", err);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (err !== 1'b0 || wr_ready !== 1'b1 || en_out !== 1'b0) begin
        bad++;
        $display("FAIL early_idle cyc=%0d err=%b wr_ready=%b en=%b want 0 1 0", i, err, wr_ready, en_out);
      end
    end
    for (int r = 5; r < D; r++) write_row(tile[r]);
    run_stream();
    for (int k = 0; k < C; k++) begin
      total++;
      if (!cap_ok || cap_en[k] !== (k < L) || cap_done[k] !== (k == L) || cap_row[k] !== exp_row(k)) begin
        bad++;
        $display("FAIL early_stream cyc=%0d ok=%b en=%b done=%b row=%h want en=%b done=%b row=%h",
                 k, cap_ok, cap_en[k], cap_done[k], cap_row[k], k < L, k == L, exp_row(k));
      end
    end
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < D; r++) tile[r] = rand_row();
    load_tile();
    set_row(rand_row());
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (wr_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_ready cyc=%0d wr_ready=%b want 0", i, wr_ready);
      end
    end
    wr_valid = 1'b0;
    run_stream();
    for (int k = 0; k < C; k++) begin
      total++;
      if (!cap_ok || cap_en[k] !== (k < L) || cap_done[k] !== (k == L) || cap_row[k] !== exp_row(k)) begin
        bad++;
        $display("FAIL bp_stream cyc=%0d ok=%b en=%b done=%b row=%h want en=%b done=%b row=%h",
                 k, cap_ok, cap_en[k], cap_done[k], cap_row[k], k < L, k == L, exp_row(k));
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int r = 0; r < D; r++) tile[r] = rand_row();
    for (int r = 0; r < D - 1; r++) write_row(tile[r]);
    set_row(tile[D-1]);
    wr_valid = 1'b1;
    start = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    start = 1'b0;
    total++;
    if (err !== 1'b1 || wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL simul_err err=%b wr_ready=%b want 1 0", err, wr_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (en_out !== 1'b0 || err !== 1'b0) begin
        bad++;
        $display("FAIL simul_idle cyc=%0d en=%b err=%b want 0 0", i, en_out, err);
      end
    end
    run_stream();
    for (int k = 0; k < C; k++) begin
      total++;
      if (!cap_ok || cap_en[k] !== (k < L) || cap_done[k] !== (k == L) || cap_row[k] !== exp_row(k)) begin
        bad++;
        $display("FAIL simul_stream cyc=%0d ok=%b en=%b done=%b row=%h want en=%b done=%b row=%h",
                 k, cap_ok, cap_en[k], cap_done[k], cap_row[k], k < L, k == L, exp_row(k));
      end
    end
  endtask

  task automatic test_reset_midstream();
    int t;
    for (int r = 0; r < D; r++) tile[r] = ramp_row(r);
    load_tile();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!en_out && t < 5) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (en_out !== 1'b1) begin
      bad++;
      $display("FAIL mid_start en=%b want 1", en_out);
    end
    repeat (12) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if (en_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bout_flat !== '0) begin
      bad++;
      $display("FAIL mid_abort en=%b busy=%b done=%b bout=%h want all zero", en_out, busy, done, bout_flat);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (wr_ready !== 1'b1 || en_out !== 1'b0) begin
      bad++;
      $display("FAIL mid_release wr_ready=%b en=%b want 1 0", wr_ready, en_out);
    end
    load_tile();
    run_stream();
    for (int k = 0; k < C; k++) begin
      total++;
      if (!cap_ok || cap_en[k] !== (k < L) || cap_done[k] !== (k == L) || cap_row[k] !== exp_row(k)) begin
        bad++;
        $display("FAIL mid_stream cyc=%0d ok=%b en=%b done=%b row=%h want en=%b done=%b row=%h",
                 k, cap_ok, cap_en[k], cap_done[k], cap_row[k], k < L, k == L, exp_row(k));
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < D; r++) for (int j = 0; j < D; j++) tile[r][j*B +: B] = (p == 0) ? B'(1) : B'(-1);
      load_tile();
      run_stream();
      for (int k = 0; k < C; k++) begin
        total++;
        if (!cap_ok || cap_en[k] !== (k < L) || cap_done[k] !== (k == L) || cap_row[k] !== exp_row(k)) begin
          bad++;
          $display("FAIL b2b_stream tile=%0d cyc=%0d ok=%b en=%b done=%b row=%h want en=%b done=%b row=%h",
                   p, k, cap_ok, cap_en[k], cap_done[k], cap_row[k], k < L, k == L, exp_row(k));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      for (int r = 0; r < D; r++) tile[r] = rand_row();
      for (int r = 0; r < D; r++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        write_row(tile[r]);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_stream();
      for (int k = 0; k < C; k++) begin
        total++;
        if (!cap_ok || cap_en[k] !== (k < L) || cap_done[k] !== (k == L) || cap_err[k] !== 1'b0 || cap_row[k] !== exp_row(k)) begin
          bad++;
          $display("FAIL rand_stream iter=%0d cyc=%0d ok=%b en=%b done=%b err=%b row=%h want en=%b done=%b row=%h",
                   n, k, cap_ok, cap_en[k], cap_done[k], cap_err[k], cap_row[k], k < L, k == L, exp_row(k));
        end
      end
    end
  endtask

  initial begin
    set_row('0);
    test_reset();
    test_fill();
    test_early_start();
    test_backpressure();
    test_simultaneous();
    test_reset_midstream();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/b_loader.md
B_LOADER -- requirements
Module: b_loader

Interface
REQ-001 Parameter BITS_AB, default 8: signed element width.
REQ-002 Parameter DIM, default 8: rows per tile and elements per row.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port wr_valid, input, 1: wr_row holds a valid row.
REQ-007 Port wr_ready, output, 1: the block can accept a row this cycle.
REQ-008 Port wr_row, input, signed [BITS_AB-1:0] x [DIM-1:0]: one B row.
REQ-009 Port start, input, 1: request to stream the buffered tile.
REQ-010 Port busy, output, 1: streaming is in progress.
REQ-011 Port done, output, 1: one-cycle pulse when streaming ends.
REQ-012 Port err, output, 1: one-cycle pulse when start is rejected.
REQ-013 Port en_out, output, 1: drives the downstream skew buffer en.
REQ-014 Port Bout, output, signed [BITS_AB-1:0] x [DIM-1:0]: drives the downstream skew buffer Bin.

Function
REQ-015 The FSM SHALL have three states: FILL, FULL and STREAM.
REQ-016 In FILL, wr_ready=1; a row is accepted when wr_valid && wr_ready; it is stored at index wr_cnt, and wr_cnt increments.
REQ-017 On accepting the row at wr_cnt==DIM-1, the FSM SHALL go to FULL and wr_ready SHALL be 0 from the next cycle.
REQ-018 In FULL, wr_ready=0 and wr_valid is ignored; start SHALL move the FSM to STREAM with st_cnt=0.
REQ-019 A start in FILL, or in STREAM, SHALL be ignored and SHALL pulse err one cycle later.
REQ-020 A start and the final-row write in the same cycle SHALL accept the write, reject the start (err pulse), and go to FULL.
REQ-021 In STREAM, st_cnt SHALL count 0 to STREAM_LEN-1; STREAM_LEN = 4*DIM (32 at DIM=8), so the downstream 5-bit en counter wraps to 0.
REQ-022 Outputs SHALL be registered, one cycle of latency after the state/st_cnt values that produce them.
REQ-023 For st_cnt=k, the next cycle SHALL present en_out=1, and Bout = row k when k<DIM, else all zeros.
REQ-024 en_out SHALL be 0 in every cycle not driven by REQ-023.
REQ-025 Bout SHALL be all zeros whenever en_out=0.
REQ-026 busy SHALL be 1 exactly when en_out=1.
REQ-027 After st_cnt=STREAM_LEN-1, the FSM SHALL return to FILL with wr_cnt=0, and done SHALL pulse coincident with the first en_out=0 cycle.
REQ-028 The row buffer SHALL NOT be cleared after streaming; FILL overwrites it.

Reset
REQ-029 On rst, the FSM SHALL enter FILL and wr_cnt and st_cnt SHALL be 0.
REQ-030 On rst, outputs SHALL be: wr_ready=1 after release, busy=0, done=0, err=0, en_out=0, Bout=all zeros.
REQ-031 The row buffer is not reset; it is never output before DIM fresh rows are written.
REQ-032 A reset in the middle of STREAM SHALL abort immediately with en_out=0.
REQ-033 The system SHALL reset the downstream skew buffer in the same cycle as this block.

Structure
REQ-034 A shared package SHALL hold the state enum and the STREAM_LEN=4*DIM constant.
REQ-035 BITS_AB and DIM SHALL remain module parameters.
REQ-036 No sub-module is required.
REQ-037 The row buffer SHALL be a DIM x DIM register array inside b_loader.

Verification
REQ-038 Fill test: write rows r=0..7 with element j = 8r+j, then start -> en_out high 32 consecutive cycles; Bout = row k on cycles 0..7, zeros on cycles 8..31; done pulses once.
REQ-039 Early start: start after 5 rows -> err pulse, FSM remains FILL, wr_ready=1, en_out stays 0.
REQ-040 Backpressure: hold wr_valid with a 9th row after 8 accepted -> wr_ready=0, row not captured; stream output matches the first 8 rows.
REQ-041 Simultaneous event: 8th row write and start in the same cycle -> write accepted, err pulses, no streaming; a later start streams correctly.
REQ-042 Reset mid-stream: assert rst at stream cycle 12 -> en_out=0 and Bout=0 immediately; after release wr_ready=1 and a full reload/stream matches the REQ-038 result.
REQ-043 Back-to-back tiles: stream tile A (all elements 1), reload tile B (all -1), stream -> the second stream carries only -1 in data cycles, with no residue from A.
